// File: rtl/bpsk_demodulator_pkg.sv
// Shared BPSK carrier constants, receiver state encoding and the sine table
// used by both the transmitter and the receiver.
package bpsk_demodulator_pkg;

  localparam int SIGNAL_WIDTH    = 8;
  localparam int WAVELENGTH      = 16;
  localparam int SINE_RESOLUTION = SIGNAL_WIDTH;
  localparam int MIDSCALE        = 1 << (SIGNAL_WIDTH - 1);
  localparam int PHASE_WIDTH     = $clog2(WAVELENGTH) + 1;
  localparam int PROD_WIDTH      = 2 * SIGNAL_WIDTH + 2;
  localparam int ACC_WIDTH       = PROD_WIDTH + $clog2(WAVELENGTH);
  localparam int CONF_THRESHOLD  = 32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    GUARD = 2'd2
  } state_e;

  // One period of offset-binary sine, 128 + 127*sin(2*pi*k/16).
  function automatic logic [SINE_RESOLUTION-1:0] sine_table(input logic [PHASE_WIDTH-2:0] idx);
    logic [SINE_RESOLUTION-1:0] val;
    case (idx)
      4'd0:    val = 8'd128;
      4'd1:    val = 8'd177;
      4'd2:    val = 8'd218;
      4'd3:    val = 8'd245;
      4'd4:    val = 8'd255;
      4'd5:    val = 8'd245;
      4'd6:    val = 8'd218;
      4'd7:    val = 8'd177;
      4'd8:    val = 8'd128;
      4'd9:    val = 8'd79;
      4'd10:   val = 8'd38;
      4'd11:   val = 8'd11;
      4'd12:   val = 8'd1;
      4'd13:   val = 8'd11;
      4'd14:   val = 8'd38;
      4'd15:   val = 8'd79;
      default: val = 8'd128;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/bpsk_demodulator_correlator.sv
// Per-symbol correlator: phase counter, template lookup, multiply-accumulate
// and hard slice. The symbol sum is exported only with BPSK_DEMOD_CONFIDENCE_EN.
module bpsk_correlator
  import bpsk_demodulator_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIGNAL_WIDTH-1:0]     sample,
  input  logic                        start,
  input  logic                        run,
  output logic                        bit_value,
  output logic                        bit_strobe
`ifdef BPSK_DEMOD_CONFIDENCE_EN
  ,
  output logic signed [ACC_WIDTH-1:0] sum
`endif
);

  localparam logic signed [SIGNAL_WIDTH:0] MID_S = MIDSCALE;

  logic [PHASE_WIDTH-1:0]        phase_q, phase_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [SIGNAL_WIDTH:0]  s_val, t_val;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext, sum_s;

  assign s_val    = $signed({1'b0, sample}) - MID_S;
  assign t_val    = $signed({1'b0, sine_table(phase_q[PHASE_WIDTH-2:0])}) - MID_S;
  assign prod     = s_val * t_val;
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign sum_s    = acc_q + prod_ext;

  // A tie (sum of exactly zero) slices to 0.
  assign bit_strobe = run && (phase_q == PHASE_WIDTH'(WAVELENGTH - 1));
  assign bit_value  = !sum_s[ACC_WIDTH-1] && (sum_s != '0);

`ifdef BPSK_DEMOD_CONFIDENCE_EN
  assign sum = sum_s;
`endif

  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    if (start) begin
      acc_d   = prod_ext;
      phase_d = PHASE_WIDTH'(1);
    end else if (run) begin
      if (bit_strobe) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum_s;
        phase_d = phase_q + PHASE_WIDTH'(1);
      end
    end else begin
      acc_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      acc_q   <= '0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK receiver top: burst-detect FSM, SIPO word assembly and guard timer.
// Optional margin/low_conf outputs are enabled by BPSK_DEMOD_CONFIDENCE_EN.
module bpsk_demodulator
  import bpsk_demodulator_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SIGNAL_WIDTH-1:0] signal,
  output logic [BITS-1:0]         data,
  output logic                    valid,
  output logic                    busy
`ifdef BPSK_DEMOD_CONFIDENCE_EN
  ,
  output logic [ACC_WIDTH-1:0]    margin,
  output logic                    low_conf
`endif
);

  localparam int CNT_WIDTH  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int ZERO_WIDTH = $clog2(WAVELENGTH) + 1;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0]       shift_q, shift_d;
  logic [BITS-1:0]       data_q, data_d;
  logic [ZERO_WIDTH-1:0] zero_cnt_q, zero_cnt_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic                  start_s, run_s, bit_s, strobe_s, word_done_s;
  logic [BITS-1:0]       word_s;

  assign start_s     = (state_q == IDLE) && (signal != '0);
  assign run_s       = (state_q == ACCUM);
  assign word_done_s = strobe_s && (bit_cnt_q == CNT_WIDTH'(BITS - 1));
  assign word_s      = {shift_q[BITS-2:0], bit_s};

`ifdef BPSK_DEMOD_CONFIDENCE_EN
  logic signed [ACC_WIDTH-1:0] sum_s;
`endif

  bpsk_correlator u_correlator (
    .clk        (clk),
    .reset      (reset),
    .sample     (signal),
    .start      (start_s),
    .run        (run_s),
    .bit_value  (bit_s),
    .bit_strobe (strobe_s)
`ifdef BPSK_DEMOD_CONFIDENCE_EN
    ,
    .sum        (sum_s)
`endif
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    zero_cnt_d = '0;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (word_done_s) begin
          data_d    = word_s;
          valid_d   = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = GUARD;
        end else if (strobe_s) begin
          shift_d   = word_s;
          bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        end else begin
          state_d = ACCUM;
        end
      end
      // Filler symbols are ignored; only a full period of silence re-arms.
      GUARD: begin
        if (signal != '0) begin
          zero_cnt_d = '0;
        end else if (zero_cnt_q == ZERO_WIDTH'(WAVELENGTH - 1)) begin
          state_d = IDLE;
        end else begin
          zero_cnt_d = zero_cnt_q + ZERO_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      zero_cnt_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      zero_cnt_q <= zero_cnt_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

`ifdef BPSK_DEMOD_CONFIDENCE_EN
  logic [ACC_WIDTH-1:0] min_q, min_d, margin_q, margin_d, abs_s, min_new_s;
  logic                 low_conf_q, low_conf_d;

  assign abs_s     = sum_s[ACC_WIDTH-1] ? $unsigned(-sum_s) : $unsigned(sum_s);
  assign min_new_s = (abs_s < min_q) ? abs_s : min_q;

  always_comb begin
    min_d      = min_q;
    margin_d   = margin_q;
    low_conf_d = 1'b0;
    if (start_s) begin
      min_d = '1;
    end else if (run_s && strobe_s) begin
      min_d = min_new_s;
      if (word_done_s) begin
        margin_d   = min_new_s;
        low_conf_d = (min_new_s < ACC_WIDTH'(CONF_THRESHOLD));
      end else begin
        low_conf_d = 1'b0;
      end
    end else begin
      min_d = min_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_q      <= '1;
      margin_q   <= '0;
      low_conf_q <= 1'b0;
    end else begin
      min_q      <= min_d;
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
    end
  end

  assign margin   = margin_q;
  assign low_conf = low_conf_q;
`endif

endmodule

// File: doc/bpsk_demodulator.md
Name: bpsk_demodulator

Overview:
- Receive-side counterpart of the BPSK modulator.
- Consumes the sampled carrier one sample per clock, correlates each symbol period against the shared sine table, and slices each symbol to one bit.
- Assembles BITS symbols into a parallel word and presents it with a one-cycle valid pulse.
- Sits between the channel/ADC sample stream and the receive framing logic.

Parameters:
- BITS, 32, number of symbols (bits) per received word.
- Carrier constants come from the shared package, not from module parameters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- signal  input  SIGNAL_WIDTH  unsigned offset-binary carrier sample; value 0 means carrier absent.
- data  output  BITS  last completed word; first received bit is at data[BITS-1].
- valid  output  1  one-cycle pulse when data updates.
- busy  output  1  high in ACCUM and GUARD.

Behaviour:
- Reset values: data=0, valid=0, busy=0, state=IDLE, phase=0, bit_cnt=0, acc=0, shift register=0, zero_cnt=0.
- Sample conversion: s = signal − MIDSCALE, where MIDSCALE = 2^(SIGNAL_WIDTH−1). Template t[phase] = SINE_TABLE[phase] − MIDSCALE. Both are signed, SIGNAL_WIDTH+1 bits.
- Arithmetic:
  - Product p = s*t, signed, 2*SIGNAL_WIDTH+2 bits.
  - acc is signed, ACC_WIDTH = 2*SIGNAL_WIDTH+2+$clog2(WAVELENGTH) bits; it cannot overflow.
- IDLE:
  - On signal≠0: the sample is phase 0. acc<=p, phase<=1, state<=ACCUM, busy=1.
  - Otherwise remain in IDLE.
- ACCUM:
  - Each cycle acc<=acc+p and phase<=phase+1.
  - At phase==WAVELENGTH−1: sum = acc+p. Bit = 1 if sum>0, else 0 (tie slices to 0). Bit shifts into the shift register LSB, MSB-first order. acc<=0, phase<=0, bit_cnt<=bit_cnt+1.
  - Samples equal to 0 inside ACCUM are treated as ordinary samples (value −MIDSCALE). There is no early abort.
- Word completion:
  - When the decision is made with bit_cnt==BITS−1, on that same edge: data<={shift[BITS−2:0],bit}, valid<=1, bit_cnt<=0, state<=GUARD.
  - valid is therefore high for exactly the cycle after the clock edge that captured the last sample of the word.
  - valid is deasserted the next cycle. data holds until the next word completes.
- GUARD:
  - zero_cnt counts consecutive signal==0 samples. Any nonzero sample clears zero_cnt.
  - When zero_cnt reaches WAVELENGTH: state<=IDLE, busy=0.
  - Any trailing or filler symbols emitted by the transmitter after the word are ignored.
- Reset in any state, including mid-word:
  - Immediately returns to IDLE and clears all state.
  - Any partial word is discarded and data is cleared to 0.
  - Reset takes priority over a coincident decision.
- Phase wraps WAVELENGTH−1→0. The phase counter is $clog2(WAVELENGTH)+1 bits wide, matching the transmitter counter.

Optional Feature:
- Macro: BPSK_DEMOD_CONFIDENCE_EN.
- When defined:
  - Adds output margin [ACC_WIDTH−1:0]: the minimum |sum| over all BITS symbols of the word. Registered with data, valid on the same cycle.
  - Adds output low_conf [1]: high with valid when margin < CONF_THRESHOLD. CONF_THRESHOLD is a package constant.
  - The running minimum resets to all-ones at word start.
- When undefined: neither port exists and there is no extra logic. Core behaviour is identical either way.

Decomposition:
- Shared package/header (extends core_params.svh): SIGNAL_WIDTH, WAVELENGTH, SINE_RESOLUTION, MIDSCALE, ACC_WIDTH, CONF_THRESHOLD, and the state enum typedef {IDLE, ACCUM, GUARD}.
- SINE_TABLE comes from the shared sine table header, so the transmitter and receiver use the same table.
- One natural sub-module: bpsk_correlator.
  - Holds the phase counter, template lookup, multiply-accumulate and slice.
  - Interface: sample in and start in; bit and bit_strobe out.
  - The top level holds the FSM, the SIPO shift register and the guard counter.

Test Plan (BITS=8, WAVELENGTH=16, SIGNAL_WIDTH=8 unless stated):
- Ideal loopback: modulator driven with 0xA5, signal fed directly → exactly one valid pulse 128 cycles after the first nonzero sample; data=0xA5; busy falls after the trailing symbol plus 16 zero samples.
- Back-to-back words: 0x00 then 0xFF, with a 16-cycle zero gap → two valid pulses with data=0x00 then 0xFF; nothing decoded during the gap.
- Noise: ±8 LSB uniform noise added to the 0x3C waveform → data=0x3C. With BPSK_DEMOD_CONFIDENCE_EN defined, margin>0 and low_conf=0.
- Reset mid-word: reset asserted for one cycle after 3 symbols of 0xA5 → data=0, valid never asserted; a fresh 0x5A burst afterwards decodes to 0x5A.
- Tie and zero handling: a symbol of all-MIDSCALE samples → that bit slices to 0. A zero sample inside ACCUM does not abort the word.
- BITS=32 with the word 0xDEADBEEF → data=0xDEADBEEF, first received bit at data[31].
